fb_dbuf: RTL
============

Name: fb_dbuf

Overview:
- Double-buffered framebuffer RAM, successor to the single-page dual-port video RAM.
- Two pages of 2**ADDR_WIDTH words each:
  - the video scanout reads the front page;
  - the CPU/blitter writes the back page through a valid/ready handshake.
- Page flip is requested at any time and committed only on the next vblank rising edge.
- A built-in clear engine fills the back page with a constant value.

Parameters:
- DATA_WIDTH, 8: pixel word width in bits.
- ADDR_WIDTH, 6: per-page address width; page depth is 2**ADDR_WIDTH.
- READ_LAT, 1: scanout read latency in cycles; legal values are 1 or 2.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- w_valid  in  1  write request.
- w_ready  out  1  write accepted when high with w_valid.
- w_adr  in  ADDR_WIDTH  back-page write address.
- w_data  in  DATA_WIDTH  write data.
- r_en  in  1  scanout read request.
- r_adr  in  ADDR_WIDTH  front-page read address.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  r_data valid.
- flip_req  in  1  one-cycle flip request pulse.
- vblank  in  1  vertical blank level from the video timing block.
- flip_pending  out  1  a flip is requested and not yet committed.
- front_sel  out  1  current front page index.
- clr_start  in  1  start back-page clear.
- clr_data  in  DATA_WIDTH  fill value, sampled with clr_start.
- clr_busy  out  1  clear in progress.

Behaviour:
- Reset (asynchronous, reset_n low):
  - front_sel=0, flip_pending=0, r_valid=0, r_data=0, clr_busy=0.
  - Internal vblank_q=0; FSM=IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-clear aborts the clear; the page is left partially filled.
- Physical RAM: 2*2**ADDR_WIDTH words, addressed {page, adr}. back = ~front_sel.
- Read path:
  - r_en high at edge N samples {front_sel, r_adr}.
  - r_data/r_valid update at edge N+READ_LAT-1, so data is visible READ_LAT cycles after the request.
  - r_valid is r_en delayed by READ_LAT; r_data holds its last value when r_valid=0.
  - A read in flight across a flip returns the page sampled at issue.
- Write path:
  - w_ready = (FSM==IDLE), combinational.
  - On w_valid&&w_ready at an edge, ram[{back,w_adr}] <= w_data.
  - Writes never touch the front page.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start: latch clr_data, cnt<=0, clr_busy<=1.
  - In CLEAR, each cycle writes ram[{back,cnt}] <= fill and increments cnt.
  - After writing cnt==2**ADDR_WIDTH-1, return to IDLE and set clr_busy<=0.
  - Total duration is exactly 2**ADDR_WIDTH cycles.
  - clr_start while in CLEAR is ignored.
  - A write accepted in the same cycle as clr_start completes; the clear then overwrites it.
- Flip:
  - flip_req sets flip_pending; further flip_req while pending has no extra effect.
  - vblank is registered as vblank_q; edge = vblank & ~vblank_q.
  - On an edge with (flip_pending | flip_req) and FSM==IDLE: front_sel toggles and flip_pending clears.
  - If FSM==CLEAR at the edge, the flip is deferred to a later vblank edge; the back page never changes mid-clear.
  - flip_req coincident with a qualifying edge flips on that edge.
- Write/read address collision across pages is impossible. Same-page collision cannot occur: reads use the front page, writes use the back page.

Optional Feature:
- Macro FB_FLIP_IRQ_EN.
- With it:
  - Add ports irq (out, 1) and irq_clr (in, 1).
  - irq sets on the edge where front_sel toggles and stays high until irq_clr.
  - Set wins over simultaneous irq_clr.
  - Reset value of irq is 0.
- Without it: ports are absent and there is no extra logic.

Decomposition:
- Package fb_pkg holds:
  - typedef fb_state_e {FB_IDLE, FB_CLEAR};
  - localparam FB_PAGES=2;
  - helper function for the {page, adr} concatenation width.
- Sub-module fb_dpram:
  - generic simple dual-port RAM, one clock;
  - registered read with an optional second output register selected by READ_LAT;
  - no reset on the storage array.
- fb_dbuf contains the FSM, flip logic and read pipeline.

Test Plan:
1. Reset then write {0x05:0xA5} via handshake, flip_req, vblank rise, read adr 0x05 -> r_data=0xA5 READ_LAT cycles later with r_valid=1; front_sel=1.
2. Write 0x3C to adr 0x10 without a flip, read adr 0x10 -> returns old front-page data, not 0x3C; flip_pending=0.
3. clr_start with clr_data=0x7E -> clr_busy high exactly 64 cycles (ADDR_WIDTH=6) and w_ready low throughout; after flip, all 64 reads return 0x7E.
4. flip_req, then vblank rise during CLEAR -> front_sel unchanged and flip_pending=1; next vblank rise after clear completes -> front_sel toggles and flip_pending=0.
5. Assert reset_n low mid-clear at cnt=20 -> all outputs at reset values immediately; after release w_ready=1 and FSM idle.
6. With FB_FLIP_IRQ_EN: flip commit -> irq=1; irq_clr in the same cycle as the next flip commit -> irq stays 1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered framebuffer.
package fb_pkg;

    typedef enum logic {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_e;

    localparam int unsigned FB_PAGES = 2;

    // Physical RAM address width: page index bits plus per-page address bits.
    function automatic int unsigned fb_phys_aw(input int unsigned aw);
        return aw + $clog2(FB_PAGES);
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM, one clock, registered read with optional second output stage.
module fb_dpram
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7,
    parameter int unsigned RL = 1
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd1_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output registers hold their value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
        end else if (re_i) begin
            rd1_q <= mem[raddr_i];
        end
    end

    generate
        if (RL == 2) begin : g_lat2
            logic          re_q;
            logic [DW-1:0] rd2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    re_q  <= 1'b0;
                    rd2_q <= '0;
                end else begin
                    re_q <= re_i;
                    if (re_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign rdata_o = rd2_q;
        end else begin : g_lat1
            assign rdata_o = rd1_q;
        end
    endgenerate

endmodule

// File: rtl/fb_dbuf.sv
// Double-buffered framebuffer: front page scanout, back page writes/clear, vblank-synchronous flip.
// Optional flip-complete interrupt enabled by defining FB_FLIP_IRQ_EN.
module fb_dbuf
    import fb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned READ_LAT   = 1
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [ADDR_WIDTH-1:0] w_adr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_adr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    input  logic                  flip_req,
    input  logic                  vblank,
    output logic                  flip_pending,
    output logic                  front_sel,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_data,
    output logic                  clr_busy
`ifdef FB_FLIP_IRQ_EN
    ,
    output logic                  irq,
    input  logic                  irq_clr
`endif
);

    localparam int unsigned PAW = fb_phys_aw(ADDR_WIDTH);

    fb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  clr_busy_q, clr_busy_d;
    logic                  front_sel_q, front_sel_d;
    logic                  flip_pending_q, flip_pending_d;
    logic                  vblank_q;
    logic [READ_LAT-1:0]   rvalid_q;

    logic                  vblank_rise;
    logic                  flip_go;
    logic                  ram_we;
    logic [PAW-1:0]        ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign w_ready = (state_q == FB_IDLE);

    // Clear engine: one back-page word per cycle, then back to idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        clr_busy_d = clr_busy_q;
        case (state_q)
            FB_IDLE: begin
                if (clr_start) begin
                    state_d    = FB_CLEAR;
                    cnt_d      = '0;
                    fill_d     = clr_data;
                    clr_busy_d = 1'b1;
                end
            end
            FB_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d    = FB_IDLE;
                    clr_busy_d = 1'b0;
                end
            end
        endcase
    end

    // Flip commits only on a vblank rising edge while no clear is running.
    always_comb begin
        vblank_rise    = vblank & ~vblank_q;
        flip_go        = vblank_rise & (flip_pending_q | flip_req) & (state_q == FB_IDLE);
        front_sel_d    = front_sel_q ^ flip_go;
        flip_pending_d = flip_go ? 1'b0 : (flip_pending_q | flip_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= FB_IDLE;
            cnt_q          <= '0;
            fill_q         <= '0;
            clr_busy_q     <= 1'b0;
            front_sel_q    <= 1'b0;
            flip_pending_q <= 1'b0;
            vblank_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fill_q         <= fill_d;
            clr_busy_q     <= clr_busy_d;
            front_sel_q    <= front_sel_d;
            flip_pending_q <= flip_pending_d;
            vblank_q       <= vblank;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_rv2
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rvalid_q <= '0;
                end else begin
                    rvalid_q <= {rvalid_q[0], r_en};
                end
            end
        end else begin : g_rv1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rvalid_q <= '0;
                end else begin
                    rvalid_q <= r_en;
                end
            end
        end
    endgenerate

`ifdef FB_FLIP_IRQ_EN
    logic irq_q;

    // A new flip wins over a simultaneous acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (flip_go) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    // Back page is always the complement of the front page.
    always_comb begin
        ram_we    = (state_q == FB_CLEAR) | (w_valid & w_ready);
        ram_waddr = {~front_sel_q, (state_q == FB_CLEAR) ? cnt_q : w_adr};
        ram_wdata = (state_q == FB_CLEAR) ? fill_q : w_data;
    end

    fb_dpram #(
        .DW (DATA_WIDTH),
        .AW (PAW),
        .RL (READ_LAT)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (r_en),
        .raddr_i ({front_sel_q, r_adr}),
        .rdata_o (r_data)
    );

    assign r_valid      = rvalid_q[READ_LAT-1];
    assign flip_pending = flip_pending_q;
    assign front_sel    = front_sel_q;
    assign clr_busy     = clr_busy_q;

endmodule
